// File: rtl/gcd_operand_dispatch.sv
`default_nettype none
// ============================================================================
// gcd_operand_dispatch : operand-pair queue feeding the GCD A/B operand FIFOs,
// discarding zero-operand pairs and keeping saturating issue/drop statistics.
// Revision: 1.0
// ============================================================================
module gcd_operand_dispatch #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [3:0]                 req_a_i,
  input  logic [3:0]                 req_b_i,
  input  logic                       a_rdy_i,
  input  logic                       b_rdy_i,
  output logic                       a_en_o,
  output logic [3:0]                 a_data_o,
  output logic                       b_en_o,
  output logic [3:0]                 b_data_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic [CNT_W-1:0]           issued_cnt_o,
  output logic [CNT_W-1:0]           drop_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0]    FULL_LVL = LW'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [7:0]       mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic       accept;
  logic       nonzero;
  logic       push;
  logic       drop;
  logic       issue;
  logic       empty;
  logic [7:0] head;

  // Ready comes from registered occupancy only, so a same-cycle pop never
  // lets a full queue accept.
  assign empty       = (level_q == '0);
  assign req_ready_o = (level_q != FULL_LVL);
  assign accept      = req_valid_i && req_ready_o;
  assign nonzero     = (req_a_i != 4'd0) && (req_b_i != 4'd0);
  assign push        = accept && nonzero && !flush_i;
  assign drop        = accept && !nonzero && !flush_i;
  assign issue       = !empty && a_rdy_i && b_rdy_i && !flush_i;

  assign head     = mem_q[rd_ptr_q];
  assign a_en_o   = issue;
  assign b_en_o   = issue;
  assign a_data_o = empty ? 4'd0 : head[7:4];
  assign b_data_o = empty ? 4'd0 : head[3:0];

  assign empty_o      = empty;
  assign level_o      = level_q;
  assign issued_cnt_o = issued_q;
  assign drop_cnt_o   = drop_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    issued_d = issued_q;
    drop_d   = drop_q;

    if (issue && (issued_q != CNT_MAX)) issued_d = issued_q + CNT_W'(1);
    if (drop && (drop_q != CNT_MAX))    drop_d   = drop_q + CNT_W'(1);

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push)  wr_ptr_d = wr_ptr_q + AW'(1);
      if (issue) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, issue})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      issued_q <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      issued_q <= issued_d;
      drop_q   <= drop_d;
    end
  end

  // Storage needs no reset: the head is masked to zero while the queue is empty.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= {req_a_i, req_b_i};
  end

endmodule
`default_nettype wire

// File: tb/tb_gcd_operand_dispatch.sv
`default_nettype none
// ============================================================================
// tb_gcd_operand_dispatch : bench for gcd_operand_dispatch (DEPTH=4, CNT_W=8).
// Revision: 1.0
// ============================================================================
module tb_gcd_operand_dispatch;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             flush_i = 1'b0;
  logic             req_valid_i = 1'b0;
  logic             req_ready_o;
  logic [3:0]       req_a_i = 4'd0;
  logic [3:0]       req_b_i = 4'd0;
  logic             a_rdy_i = 1'b1;
  logic             b_rdy_i = 1'b1;
  logic             a_en_o, b_en_o;
  logic [3:0]       a_data_o, b_data_o;
  logic             empty_o;
  logic [$clog2(DEPTH):0] level_o;
  logic [CNT_W-1:0] issued_cnt_o, drop_cnt_o;

  gcd_operand_dispatch #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_a_i(req_a_i), .req_b_i(req_b_i),
    .a_rdy_i(a_rdy_i), .b_rdy_i(b_rdy_i),
    .a_en_o(a_en_o), .a_data_o(a_data_o),
    .b_en_o(b_en_o), .b_data_o(b_data_o),
    .empty_o(empty_o), .level_o(level_o),
    .issued_cnt_o(issued_cnt_o), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed { logic [3:0] a; logic [3:0] b; } pair_t;
  typedef struct { logic [3:0] a; logic [3:0] b; int exp_drop; int exp_iss; } vec_t;

  int    checks = 0;
  int    failures = 0;
  pair_t sb[$];
  int    exp_iss = 0;
  int    exp_drop = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard model: state sampled between edges predicts the next edge.
  always @(negedge clk_i) begin
    if (rst_i) begin
      sb.delete();
      exp_iss  = 0;
      exp_drop = 0;
    end else begin
      int    sz;
      bit    exp_en;
      pair_t p;
      sz = sb.size();
      chk("level", int'(level_o), sz);
      chk("empty", int'(empty_o), int'(sz == 0));
      chk("req_ready", int'(req_ready_o), int'(sz != DEPTH));
      chk("issued_cnt", int'(issued_cnt_o), exp_iss);
      chk("drop_cnt", int'(drop_cnt_o), exp_drop);
      exp_en = (sz != 0) && a_rdy_i && b_rdy_i && !flush_i;
      chk("a_en", int'(a_en_o), int'(exp_en));
      chk("b_en", int'(b_en_o), int'(exp_en));
      if (sz == 0) begin
        chk("a_data_empty", int'(a_data_o), 0);
        chk("b_data_empty", int'(b_data_o), 0);
      end else begin
        chk("a_data_head", int'(a_data_o), int'(sb[0].a));
        chk("b_data_head", int'(b_data_o), int'(sb[0].b));
      end
      if (exp_en) begin
        p = sb.pop_front();
        if (exp_iss != CMAX) exp_iss++;
      end
      if (flush_i) begin
        sb.delete();
      end else if (req_valid_i && sz != DEPTH) begin
        if (req_a_i == 4'd0 || req_b_i == 4'd0) begin
          if (exp_drop != CMAX) exp_drop++;
        end else begin
          p.a = req_a_i;
          p.b = req_b_i;
          sb.push_back(p);
        end
      end
    end
  end

  // Present a request and hold it until the handshake edge; valid stays high.
  task automatic send(input logic [3:0] a, input logic [3:0] b);
    bit done;
    done = 1'b0;
    req_valid_i = 1'b1;
    req_a_i = a;
    req_b_i = b;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk_i);
      if (req_ready_o) begin
        @(posedge clk_i);
        #1;
        done = 1'b1;
      end
    end
    if (!done) chk("accept_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    req_valid_i = 1'b0;
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk_i);
    #2 rst_i = 1'b1;
    @(posedge clk_i);
    #2 rst_i = 1'b0;
    #1;
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{a: 4'd12, b: 4'd8,  exp_drop: 0, exp_iss: 1};
    vecs[1] = '{a: 4'd0,  b: 4'd5,  exp_drop: 1, exp_iss: 1};
    vecs[2] = '{a: 4'd6,  b: 4'd0,  exp_drop: 2, exp_iss: 1};
    vecs[3] = '{a: 4'd0,  b: 4'd0,  exp_drop: 3, exp_iss: 1};
    vecs[4] = '{a: 4'd15, b: 4'd5,  exp_drop: 3, exp_iss: 2};

    repeat (2) @(posedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    chk("rst_level", int'(level_o), 0);
    chk("rst_empty", int'(empty_o), 1);
    chk("rst_ready", int'(req_ready_o), 1);
    chk("rst_en", int'(a_en_o | b_en_o), 0);

    // Single requests and zero-operand filtering, ready inputs high.
    for (int i = 0; i < 5; i++) begin
      send(vecs[i].a, vecs[i].b);
      idle(2);
      chk("vec_drop_cnt", int'(drop_cnt_o), vecs[i].exp_drop);
      chk("vec_issued_cnt", int'(issued_cnt_o), vecs[i].exp_iss);
      chk("vec_empty", int'(empty_o), 1);
    end

    // Backpressure on B: four fit, fifth waits for a pop, order preserved.
    do_reset();
    b_rdy_i = 1'b0;
    send(4'd3, 4'd9);
    send(4'd4, 4'd6);
    send(4'd7, 4'd14);
    send(4'd10, 4'd5);
    req_a_i = 4'd9;
    req_b_i = 4'd9;
    repeat (3) @(posedge clk_i);
    #1;
    chk("full_level", int'(level_o), DEPTH);
    chk("full_ready", int'(req_ready_o), 0);
    chk("full_en", int'(a_en_o | b_en_o), 0);
    b_rdy_i = 1'b1;
    send(4'd9, 4'd9);
    idle(6);
    chk("bp_issued", int'(issued_cnt_o), 5);

    // Steady state from full: one accept and one issue per cycle, wrapping.
    b_rdy_i = 1'b0;
    for (int i = 0; i < 4; i++) send(4'(i + 1), 4'(15 - i));
    b_rdy_i = 1'b1;
    for (int i = 0; i < 12; i++)
      send(4'($urandom_range(15, 1)), 4'($urandom_range(15, 1)));
    chk("steady_level", int'(level_o), 3);
    idle(6);
    chk("steady_issued", int'(issued_cnt_o), 21);

    // Flush with a same-cycle zero-operand request and downstream ready.
    b_rdy_i = 1'b0;
    send(4'd1, 4'd2);
    send(4'd3, 4'd4);
    send(4'd5, 4'd6);
    req_valid_i = 1'b1;
    req_a_i = 4'd0;
    req_b_i = 4'd3;
    flush_i = 1'b1;
    b_rdy_i = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    req_valid_i = 1'b0;
    chk("flush_level", int'(level_o), 0);
    chk("flush_drop", int'(drop_cnt_o), 0);
    chk("flush_issued", int'(issued_cnt_o), 21);
    idle(2);

    // Asynchronous reset mid-stream with two pairs queued.
    b_rdy_i = 1'b0;
    send(4'd7, 4'd7);
    send(4'd8, 4'd8);
    req_valid_i = 1'b0;
    b_rdy_i = 1'b1;
    #1 rst_i = 1'b1;
    #1;
    chk("arst_level", int'(level_o), 0);
    chk("arst_empty", int'(empty_o), 1);
    chk("arst_issued", int'(issued_cnt_o), 0);
    chk("arst_en", int'(a_en_o | b_en_o), 0);
    chk("arst_data", int'({a_data_o, b_data_o}), 0);
    @(posedge clk_i);
    #2 rst_i = 1'b0;
    idle(3);

    // Drop counter saturation.
    for (int i = 0; i < 260; i++) send(4'd0, 4'(i % 16));
    idle(2);
    chk("drop_sat", int'(drop_cnt_o), CMAX);
    chk("sat_issued", int'(issued_cnt_o), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
